// File: rtl/writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage_pkg
// Description : Shared types and constants for the writeback stage: FSM state
//               encoding, write-data select codes, default memory timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_stage_pkg;

  // Writeback FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_e;

  // Write-data select codes
  localparam logic [1:0] WD_MEM_WORD = 2'b00;
  localparam logic [1:0] WD_MEM_BYTE = 2'b01;
  localparam logic [1:0] WD_IMM      = 2'b10;
  localparam logic [1:0] WD_ALU      = 2'b11;

  // Default number of WAIT_MEM cycles tolerated before a load is aborted
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage
`default_nettype wire

// File: rtl/writeback_stage_byte_extract.sv
`default_nettype none
// ============================================================================
// Module      : byte_extract
// Description : Selects one big-endian byte lane of a 32-bit word and sign- or
//               zero-extends it to 32 bits. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_extract (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0] byte_sel;

  // Lane 00 is the most significant byte (big-endian numbering)
  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'b00:   byte_sel = word[31:24];
      2'b01:   byte_sel = word[23:16];
      2'b10:   byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
  end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Pipeline writeback stage. Accepts one instruction bundle,
//               optionally waits for a data-memory read (with timeout), then
//               issues a single register-file write.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  wdata_ctrl,
  input  logic        reg_wen,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] alu_result,
  input  logic [31:0] imm,
  input  logic [1:0]  mem_addr_lo,
  input  logic        byte_signed,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              reg_wen_q, reg_wen_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       alu_q, alu_d;
  logic [31:0]       imm_q, imm_d;
  logic [1:0]        lane_q, lane_d;
  logic              signed_q, signed_d;
  logic [31:0]       word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [4:0]        last_waddr_q, last_waddr_d;
  logic [31:0]       last_wdata_q, last_wdata_d;

  logic              accept;
  logic [31:0]       byte_ext;
  logic [31:0]       wdata_sel;

  byte_extract u_byte_extract (
    .word     (word_q),
    .lane     (lane_q),
    .sign_ext (signed_q),
    .result   (byte_ext)
  );

  // Handshake, memory request and write-port outputs; address/data hold their
  // last written values whenever no write is issued
  always_comb begin
    in_ready = (state_q != WAIT_MEM);
    accept   = in_valid & in_ready;
    mem_req  = (state_q == WAIT_MEM);
    rf_we    = (state_q == WRITE) & reg_wen_q & (rd_q != 5'd0);
    case (ctrl_q)
      WD_MEM_WORD: wdata_sel = word_q;
      WD_MEM_BYTE: wdata_sel = byte_ext;
      WD_IMM:      wdata_sel = imm_q;
      default:     wdata_sel = alu_q;
    endcase
    rf_waddr    = rf_we ? rd_q : last_waddr_q;
    rf_wdata    = rf_we ? wdata_sel : last_wdata_q;
    err_timeout = err_q;
  end

  // Next-state logic: bundle capture, load wait with timeout, write tracking
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    reg_wen_d    = reg_wen_q;
    rd_d         = rd_q;
    alu_d        = alu_q;
    imm_d        = imm_q;
    lane_d       = lane_q;
    signed_d     = signed_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    last_waddr_d = last_waddr_q;
    last_wdata_d = last_wdata_q;

    case (state_q)
      IDLE, WRITE: begin
        if (accept) begin
          ctrl_d    = wdata_ctrl;
          reg_wen_d = reg_wen;
          rd_d      = rd_addr;
          alu_d     = alu_result;
          imm_d     = imm;
          lane_d    = mem_addr_lo;
          signed_d  = byte_signed;
          cnt_d     = '0;
          state_d   = (wdata_ctrl == WD_MEM_WORD || wdata_ctrl == WD_MEM_BYTE)
                      ? WAIT_MEM : WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_MEM: begin
        if (mem_ack) begin
          word_d  = mem_rdata;
          cnt_d   = '0;
          state_d = WRITE;
        end else if (cnt_q == CNT_LAST) begin
          // Abandon the load: no register write is issued
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (rf_we) begin
      last_waddr_d = rd_q;
      last_wdata_d = wdata_sel;
    end
  end

  // State and captured-field registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ctrl_q       <= '0;
      reg_wen_q    <= 1'b0;
      rd_q         <= '0;
      alu_q        <= '0;
      imm_q        <= '0;
      lane_q       <= '0;
      signed_q     <= 1'b0;
      word_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      last_waddr_q <= '0;
      last_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      reg_wen_q    <= reg_wen_d;
      rd_q         <= rd_d;
      alu_q        <= alu_d;
      imm_q        <= imm_d;
      lane_q       <= lane_d;
      signed_q     <= signed_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      last_waddr_q <= last_waddr_d;
      last_wdata_q <= last_wdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed self-checking bench for writeback_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  wdata_ctrl;
  logic        reg_wen;
  logic [4:0]  rd_addr;
  logic [31:0] alu_result;
  logic [31:0] imm;
  logic [1:0]  mem_addr_lo;
  logic        byte_signed;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  writeback_stage dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .wdata_ctrl  (wdata_ctrl),
    .reg_wen     (reg_wen),
    .rd_addr     (rd_addr),
    .alu_result  (alu_result),
    .imm         (imm),
    .mem_addr_lo (mem_addr_lo),
    .byte_signed (byte_signed),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .err_timeout (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_bundle(input logic [1:0] c, input logic w, input logic [4:0] rd,
                            input logic [31:0] a, input logic [31:0] i,
                            input logic [1:0] lane, input logic s);
    in_valid    = 1'b1;
    wdata_ctrl  = c;
    reg_wen     = w;
    rd_addr     = rd;
    alu_result  = a;
    imm         = i;
    mem_addr_lo = lane;
    byte_signed = s;
  endtask

  int n;
  logic seen_we;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; wdata_ctrl = 2'b00; reg_wen = 1'b0;
    rd_addr = '0; alu_result = '0; imm = '0; mem_addr_lo = '0; byte_signed = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_req",  32'(mem_req),  32'd0);
    chk("rst_rf_we",    32'(rf_we),    32'd0);
    chk("rst_waddr",    32'(rf_waddr), 32'd0);
    chk("rst_wdata",    rf_wdata,      32'd0);
    chk("rst_err",      32'(err_timeout), 32'd0);
    reset_n = 1'b1;
    tick();

    // ALU op: write one cycle after acceptance
    set_bundle(2'b11, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 2'b00, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("alu_we",    32'(rf_we),    32'd1);
    chk("alu_waddr", 32'(rf_waddr), 32'd5);
    chk("alu_wdata", rf_wdata,      32'h1234_5678);
    chk("alu_ready", 32'(in_ready), 32'd1);
    tick();
    chk("alu_we_off",    32'(rf_we), 32'd0);
    chk("alu_wdata_hold", rf_wdata,  32'h1234_5678);
    chk("alu_waddr_hold", 32'(rf_waddr), 32'd5);

    // Signed byte load, lane 01, ack on third WAIT_MEM cycle
    set_bundle(2'b01, 1'b1, 5'd7, 32'h0, 32'h0, 2'b01, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("ld_mem_req1", 32'(mem_req),  32'd1);
    chk("ld_ready0",   32'(in_ready), 32'd0);
    chk("ld_we_wait",  32'(rf_we),    32'd0);
    tick();
    chk("ld_mem_req2", 32'(mem_req), 32'd1);
    tick();
    chk("ld_mem_req3", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0080_FF00;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("ldb_we",    32'(rf_we),    32'd1);
    chk("ldb_waddr", 32'(rf_waddr), 32'd7);
    chk("ldb_wdata", rf_wdata,      32'hFFFF_FF80);
    chk("ldb_mreq0", 32'(mem_req),  32'd0);
    tick();
    chk("ldb_we_off", 32'(rf_we), 32'd0);

    // Unsigned byte load, lane 10: 0xFF zero-extended
    set_bundle(2'b01, 1'b1, 5'd8, 32'h0, 32'h0, 2'b10, 1'b0);
    tick();
    in_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0080_FF00;
    tick();
    mem_ack = 1'b0;
    chk("ldu_wdata", rf_wdata, 32'h0000_00FF);
    tick();

    // Word load with immediate ack
    set_bundle(2'b00, 1'b1, 5'd9, 32'h0, 32'h0, 2'b11, 1'b1);
    tick();
    in_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    chk("ldw_we",    32'(rf_we),    32'd1);
    chk("ldw_waddr", 32'(rf_waddr), 32'd9);
    chk("ldw_wdata", rf_wdata,      32'hDEAD_BEEF);
    tick();

    // Back-to-back immediates on rd 1,2,3 with in_valid held high
    set_bundle(2'b10, 1'b1, 5'd1, 32'h0, 32'h0000_00A1, 2'b00, 1'b0);
    tick();
    set_bundle(2'b10, 1'b1, 5'd2, 32'h0, 32'h0000_00A2, 2'b00, 1'b0);
    chk("b2b1_we",    32'(rf_we),    32'd1);
    chk("b2b1_waddr", 32'(rf_waddr), 32'd1);
    chk("b2b1_wdata", rf_wdata,      32'h0000_00A1);
    tick();
    set_bundle(2'b10, 1'b1, 5'd3, 32'h0, 32'h0000_00A3, 2'b00, 1'b0);
    chk("b2b2_we",    32'(rf_we),    32'd1);
    chk("b2b2_waddr", 32'(rf_waddr), 32'd2);
    chk("b2b2_wdata", rf_wdata,      32'h0000_00A2);
    tick();
    in_valid = 1'b0;
    chk("b2b3_we",    32'(rf_we),    32'd1);
    chk("b2b3_waddr", 32'(rf_waddr), 32'd3);
    chk("b2b3_wdata", rf_wdata,      32'h0000_00A3);
    tick();
    chk("b2b_end_we", 32'(rf_we), 32'd0);

    // rd 0 and reg_wen 0 must not write; outputs hold the last write
    set_bundle(2'b11, 1'b1, 5'd0, 32'hCAFE_0000, 32'h0, 2'b00, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("rd0_we",    32'(rf_we), 32'd0);
    chk("rd0_hold",  rf_wdata,   32'h0000_00A3);
    tick();
    set_bundle(2'b11, 1'b0, 5'd4, 32'hCAFE_0001, 32'h0, 2'b00, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("nowen_we",    32'(rf_we),    32'd0);
    chk("nowen_waddr", 32'(rf_waddr), 32'd3);
    tick();

    // Load with no ack: mem_req high for 255 cycles, then abort
    set_bundle(2'b00, 1'b1, 5'd10, 32'h0, 32'h0, 2'b00, 1'b0);
    tick();
    in_valid = 1'b0;
    n = 0; seen_we = 1'b0;
    while (mem_req === 1'b1 && n < 400) begin
      n++;
      if (rf_we === 1'b1) seen_we = 1'b1;
      tick();
    end
    chk("to_cycles", 32'(n),           32'd255);
    chk("to_err",    32'(err_timeout), 32'd1);
    chk("to_ready",  32'(in_ready),    32'd1);
    chk("to_no_we",  32'(seen_we | rf_we), 32'd0);
    // Stray ack outside WAIT_MEM is ignored
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_we",  32'(rf_we),   32'd0);
    chk("stray_ack_req", 32'(mem_req), 32'd0);
    chk("err_sticky",    32'(err_timeout), 32'd1);

    // Reset while waiting for memory abandons the load
    set_bundle(2'b00, 1'b1, 5'd11, 32'h0, 32'h0, 2'b00, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("rw_req_before", 32'(mem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rw_req_async",  32'(mem_req),     32'd0);
    chk("rw_err_clr",    32'(err_timeout), 32'd0);
    chk("rw_wdata_clr",  rf_wdata,         32'd0);
    tick();
    reset_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    mem_ack = 1'b0;
    chk("rw_we",    32'(rf_we),    32'd0);
    chk("rw_req",   32'(mem_req),  32'd0);
    chk("rw_ready", 32'(in_ready), 32'd1);
    tick();
    chk("rw_we2",   32'(rf_we),    32'd0);
    chk("rw_waddr", 32'(rf_waddr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
